// File: rtl/deser_queue_top.sv
// Serial-to-parallel deserializer feeding an 8-entry byte FIFO, single clock domain.
// Optional macro DESER_MSB_FIRST_EN: store the first received bit at the word MSB (default: LSB first).
module deser_queue_top #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int LEN_WIDTH  = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_in,
  input  logic                  write_in,
  output logic                  status_out,
  input  logic                  dequeue_in,
  output logic [LEN_WIDTH-1:0]  len_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RX   = 2'd1,
    S_PUSH = 2'd2,
    S_GAP  = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [LEN_WIDTH-1:0]   count_q, count_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic                   wr_prev_q, wr_prev_d;
  logic                   deq_prev_q, deq_prev_d;
  logic [DATA_WIDTH-1:0]  mem_q [DEPTH];

  logic wr_evt;
  logic deq_evt;
  logic pop;
  logic push;
  logic full;

  assign wr_evt  = write_in & ~wr_prev_q;
  assign deq_evt = dequeue_in & ~deq_prev_q;
  assign full    = (count_q == LEN_WIDTH'(DEPTH));
  assign pop     = deq_evt && (count_q != '0);

  // Deserializer FSM; S_IDLE only exists so status_out stays low through reset.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    push    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_RX;
      S_RX: begin
        if (wr_evt) begin
`ifdef DESER_MSB_FIRST_EN
          shift_d = {shift_q[DATA_WIDTH-2:0], data_in};
`else
          shift_d[cnt_q] = data_in;
`endif
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(DATA_WIDTH - 1)) begin
            state_d = S_PUSH;
          end
        end
      end
      S_PUSH: begin
        // A pop in the same cycle frees a slot even when full.
        if (!full || pop) begin
          push    = 1'b1;
          cnt_d   = '0;
          state_d = S_GAP;
        end
      end
      S_GAP:   state_d = S_RX;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wr_prev_d  = write_in;
    deq_prev_d = dequeue_in;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      data_out_d = mem_q[rd_ptr_q];
    end
    case ({push, pop})
      2'b10:   count_d = count_q + LEN_WIDTH'(1);
      2'b01:   count_d = count_q - LEN_WIDTH'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
      wr_prev_q  <= 1'b0;
      deq_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
      wr_prev_q  <= wr_prev_d;
      deq_prev_q <= deq_prev_d;
    end
  end

  // Storage is not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem_q[wr_ptr_q] <= shift_q;
    end
  end

  assign status_out = (state_q == S_RX);
  assign len_out    = count_q;
  assign data_out   = data_out_q;

endmodule

// File: tb/tb_deser_queue_top.sv
// Directed self-checking bench for deser_queue_top; expected words follow DESER_MSB_FIRST_EN.
module tb_deser_queue_top;

  logic       clock;
  logic       reset;
  logic       data_in;
  logic       write_in;
  logic       status_out;
  logic       dequeue_in;
  logic [3:0] len_out;
  logic [7:0] data_out;

  int checks = 0;
  int errors = 0;

  deser_queue_top #(
    .DATA_WIDTH(8),
    .DEPTH(8),
    .LEN_WIDTH(4)
  ) dut (
    .clock(clock),
    .reset(reset),
    .data_in(data_in),
    .write_in(write_in),
    .status_out(status_out),
    .dequeue_in(dequeue_in),
    .len_out(len_out),
    .data_out(data_out)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", tag, got, exp);
    end
  endtask

  // Word the DUT should hold after receiving v's bits in order v[0]..v[7].
  function automatic logic [7:0] xw(input logic [7:0] v);
    logic [7:0] r;
`ifdef DESER_MSB_FIRST_EN
    for (int i = 0; i < 8; i++) r[7-i] = v[i];
`else
    r = v;
`endif
    return r;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (status_out !== 1'b1 && n < 400) begin
      @(negedge clock);
      n++;
    end
    if (status_out !== 1'b1) check("ready_timeout", {31'd0, status_out}, 32'd1);
  endtask

  task automatic send_bit(input logic b, inout int lows);
    @(negedge clock);
    data_in  = b;
    write_in = 1'b1;
    repeat (10) begin
      @(negedge clock);
      if (status_out === 1'b0) lows++;
    end
    write_in = 1'b0;
    repeat (9) begin
      @(negedge clock);
      if (status_out === 1'b0) lows++;
    end
  endtask

  task automatic send_byte(input logic [7:0] v, output int lows);
    int l;
    wait_ready();
    l = 0;
    for (int i = 0; i < 8; i++) send_bit(v[i], l);
    lows = l;
  endtask

  task automatic pop_pulse(input int hold);
    @(negedge clock);
    dequeue_in = 1'b1;
    repeat (hold) @(negedge clock);
    dequeue_in = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int lows;
    logic [7:0] words [8];
    reset      = 1'b1;
    data_in    = 1'b0;
    write_in   = 1'b0;
    dequeue_in = 1'b0;

    // Reset and release
    repeat (3) @(negedge clock);
    check("rst_status", {31'd0, status_out}, 32'd0);
    check("rst_len", {28'd0, len_out}, 32'd0);
    check("rst_data", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("rel_status", {31'd0, status_out}, 32'd1);
    check("rel_len", {28'd0, len_out}, 32'd0);

    // First word with long strobes
    send_byte(8'h99, lows);
    check("w0_low_pulse", {31'd0, (lows >= 2)}, 32'd1);
    check("w0_status_back", {31'd0, status_out}, 32'd1);
    check("w0_len", {28'd0, len_out}, 32'd1);
    pop_pulse(3);
    check("w0_data", {24'd0, data_out}, {24'd0, xw(8'h99)});
    check("w0_len_after_pop", {28'd0, len_out}, 32'd0);

    // Three words, one long dequeue pulse pops exactly once
    send_byte(8'hF0, lows);
    send_byte(8'h0F, lows);
    send_byte(8'hAA, lows);
    check("q3_len", {28'd0, len_out}, 32'd3);
    pop_pulse(200);
    check("q3_long_pop_data", {24'd0, data_out}, {24'd0, xw(8'hF0)});
    check("q3_long_pop_len", {28'd0, len_out}, 32'd2);
    pop_pulse(2);
    check("q3_pop2_data", {24'd0, data_out}, {24'd0, xw(8'h0F)});
    pop_pulse(2);
    check("q3_pop3_data", {24'd0, data_out}, {24'd0, xw(8'hAA)});
    check("q3_empty_len", {28'd0, len_out}, 32'd0);

    // Fill, stall a ninth word, then drain across the pointer wrap
    for (int i = 0; i < 8; i++) begin
      words[i] = 8'(i + 1);
      send_byte(words[i], lows);
    end
    check("full_len", {28'd0, len_out}, 32'd8);
    send_byte(8'h55, lows);
    repeat (5) @(negedge clock);
    check("stall_status", {31'd0, status_out}, 32'd0);
    check("stall_len", {28'd0, len_out}, 32'd8);
    pop_pulse(2);
    check("stall_pop_data", {24'd0, data_out}, {24'd0, xw(8'h01)});
    check("stall_pop_len", {28'd0, len_out}, 32'd8);
    check("stall_release_status", {31'd0, status_out}, 32'd1);
    for (int i = 1; i < 8; i++) begin
      pop_pulse(2);
      check($sformatf("drain_%0d", i), {24'd0, data_out}, {24'd0, xw(words[i])});
    end
    pop_pulse(2);
    check("drain_ninth", {24'd0, data_out}, {24'd0, xw(8'h55)});
    check("drain_len", {28'd0, len_out}, 32'd0);

    // Pop while empty
    pop_pulse(2);
    check("empty_pop_data", {24'd0, data_out}, {24'd0, xw(8'h55)});
    check("empty_pop_len", {28'd0, len_out}, 32'd0);

    // Reset in the middle of a word
    lows = 0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, lows);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    check("midrst_status", {31'd0, status_out}, 32'd0);
    check("midrst_data", {24'd0, data_out}, 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("midrst_rel_status", {31'd0, status_out}, 32'd1);
    send_byte(8'h3C, lows);
    check("midrst_len", {28'd0, len_out}, 32'd1);
    pop_pulse(2);
    check("midrst_word", {24'd0, data_out}, {24'd0, xw(8'h3C)});

    // Single leading one: lands at bit 7 when MSB first, bit 0 otherwise
    send_byte(8'h01, lows);
    pop_pulse(2);
`ifdef DESER_MSB_FIRST_EN
    check("bit_order", {24'd0, data_out}, 32'h80);
`else
    check("bit_order", {24'd0, data_out}, 32'h01);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
